// File: rtl/pkt_meta_pair_sched.sv
// Read scheduler pairing packet-buffer words with parser metadata entries.
// Streams each packet to the rewrite stage, recovers from FIFO desync and counts traffic/errors.
module pkt_meta_pair_sched #(
  parameter int META_WIDTH = 128,
  parameter int CNT_W      = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_pkt_empty,
  input  logic [133:0]          i_pkt_dout,
  output logic                  o_pkt_rden,
  input  logic                  i_meta_empty,
  input  logic [META_WIDTH-1:0] i_meta_dout,
  output logic                  o_meta_rden,
  input  logic                  i_out_ready,
  output logic                  o_pkt_valid,
  output logic [133:0]          o_pkt,
  output logic                  o_meta_valid,
  output logic [META_WIDTH-1:0] o_meta,
  output logic [CNT_W-1:0]      o_pkt_cnt,
  output logic [CNT_W-1:0]      o_resync_cnt,
  output logic [CNT_W-1:0]      o_trunc_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_RESYNC} state_e;

  state_e                state_q, state_d;
  logic                  pkt_pop, meta_pop, fwd, pkt_done, trunc, resync_drop;
  logic                  is_head, is_tail;
  logic                  pkt_valid_q, meta_valid_q;
  logic [133:0]          pkt_q;
  logic [META_WIDTH-1:0] meta_q;
  logic [CNT_W-1:0]      pkt_cnt_q, resync_cnt_q, trunc_cnt_q;

  // Tag bit 0 marks a packet start, bit 1 a packet end; 2'b11 is both.
  assign is_head = i_pkt_dout[132];
  assign is_tail = i_pkt_dout[133];

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d     = state_q;
    pkt_pop     = 1'b0;
    meta_pop    = 1'b0;
    fwd         = 1'b0;
    pkt_done    = 1'b0;
    trunc       = 1'b0;
    resync_drop = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!i_pkt_empty && i_out_ready) begin
          if (!is_head) begin
            state_d = S_RESYNC;
          end else if (!i_meta_empty) begin
            pkt_pop  = 1'b1;
            meta_pop = 1'b1;
            fwd      = 1'b1;
            if (is_tail) pkt_done = 1'b1;
            else         state_d  = S_SEND;
          end
        end
      end
      S_SEND: begin
        if (!i_pkt_empty && i_out_ready) begin
          if (is_head) begin
            // Left in the FIFO: IDLE pops it together with its own metadata.
            trunc   = 1'b1;
            state_d = S_IDLE;
          end else begin
            pkt_pop = 1'b1;
            fwd     = 1'b1;
            if (is_tail) begin
              pkt_done = 1'b1;
              state_d  = S_IDLE;
            end
          end
        end
      end
      S_RESYNC: begin
        if (!i_pkt_empty) begin
          if (is_head) begin
            state_d = S_IDLE;
          end else begin
            pkt_pop     = 1'b1;
            resync_drop = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Pops are suppressed while reset is held so FIFO contents survive a reset.
  assign o_pkt_rden  = pkt_pop & i_rst_n;
  assign o_meta_rden = meta_pop & i_rst_n;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && (v != '1)) ? v + 1'b1 : v;
  endfunction

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= S_IDLE;
      pkt_valid_q  <= 1'b0;
      meta_valid_q <= 1'b0;
      pkt_q        <= '0;
      meta_q       <= '0;
      pkt_cnt_q    <= '0;
      resync_cnt_q <= '0;
      trunc_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      pkt_valid_q  <= fwd;
      meta_valid_q <= meta_pop;
      if (fwd)      pkt_q  <= i_pkt_dout;
      if (meta_pop) meta_q <= i_meta_dout;
      pkt_cnt_q    <= sat_inc(pkt_cnt_q, pkt_done);
      resync_cnt_q <= sat_inc(resync_cnt_q, resync_drop);
      trunc_cnt_q  <= sat_inc(trunc_cnt_q, trunc);
    end
  end

  assign o_pkt_valid  = pkt_valid_q;
  assign o_pkt        = pkt_q;
  assign o_meta_valid = meta_valid_q;
  assign o_meta       = meta_q;
  assign o_pkt_cnt    = pkt_cnt_q;
  assign o_resync_cnt = resync_cnt_q;
  assign o_trunc_cnt  = trunc_cnt_q;

endmodule

// File: tb/tb_pkt_meta_pair_sched.sv
// Scoreboard bench for pkt_meta_pair_sched: show-ahead FIFO models feed the DUT,
// expected output words are queued with the stimulus and popped as the DUT emits them.
module tb_pkt_meta_pair_sched;
  localparam int MW = 128;
  localparam int CW = 32;

  logic           i_clk = 1'b0;
  logic           i_rst_n = 1'b0;
  logic           i_pkt_empty = 1'b1;
  logic [133:0]   i_pkt_dout = '0;
  logic           o_pkt_rden;
  logic           i_meta_empty = 1'b1;
  logic [MW-1:0]  i_meta_dout = '0;
  logic           o_meta_rden;
  logic           i_out_ready = 1'b1;
  logic           o_pkt_valid;
  logic [133:0]   o_pkt;
  logic           o_meta_valid;
  logic [MW-1:0]  o_meta;
  logic [CW-1:0]  o_pkt_cnt, o_resync_cnt, o_trunc_cnt;

  pkt_meta_pair_sched #(.META_WIDTH(MW), .CNT_W(CW)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_pkt_empty(i_pkt_empty), .i_pkt_dout(i_pkt_dout), .o_pkt_rden(o_pkt_rden),
    .i_meta_empty(i_meta_empty), .i_meta_dout(i_meta_dout), .o_meta_rden(o_meta_rden),
    .i_out_ready(i_out_ready),
    .o_pkt_valid(o_pkt_valid), .o_pkt(o_pkt),
    .o_meta_valid(o_meta_valid), .o_meta(o_meta),
    .o_pkt_cnt(o_pkt_cnt), .o_resync_cnt(o_resync_cnt), .o_trunc_cnt(o_trunc_cnt)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [133:0]  pkt;
    logic          mv;
    logic [MW-1:0] meta;
  } exp_t;

  logic [133:0]  pkt_fifo[$];
  logic [MW-1:0] meta_fifo[$];
  exp_t          exp_q[$];
  int            checks = 0;
  int            errors = 0;
  int            out_seen = 0;
  int            exp_pkt_cnt = 0, exp_resync_cnt = 0, exp_trunc_cnt = 0;

  function automatic logic [133:0] mk(input logic [1:0] tag, input logic [31:0] v);
    return {tag, 4'hF, 96'd0, v};
  endfunction

  function automatic logic [MW-1:0] mkm(input logic [31:0] v);
    return {4{v}};
  endfunction

  task automatic refresh();
    i_pkt_empty  = (pkt_fifo.size() == 0);
    i_pkt_dout   = (pkt_fifo.size() != 0) ? pkt_fifo[0] : '0;
    i_meta_empty = (meta_fifo.size() == 0);
    i_meta_dout  = (meta_fifo.size() != 0) ? meta_fifo[0] : '0;
  endtask

  task automatic push_pkt(input logic [1:0] tag, input logic [31:0] v);
    pkt_fifo.push_back(mk(tag, v));
    refresh();
  endtask

  task automatic push_meta(input logic [31:0] v);
    meta_fifo.push_back(mkm(v));
    refresh();
  endtask

  task automatic expect_word(input logic [1:0] tag, input logic [31:0] v,
                             input logic mv, input logic [31:0] mval);
    exp_t e;
    e.pkt  = mk(tag, v);
    e.mv   = mv;
    e.meta = mkm(mval);
    exp_q.push_back(e);
  endtask

  // One clock: pops are decided from the rden values seen before the edge,
  // outputs are compared 1 time unit after the edge.
  task automatic tick();
    logic pp, mp;
    exp_t e;
    #1;
    pp = o_pkt_rden;
    mp = o_meta_rden;
    @(posedge i_clk);
    #1;
    if (pp) begin
      checks++;
      if (pkt_fifo.size() == 0) begin
        errors++;
        $display("FAIL pkt_underflow: o_pkt_rden=1 with empty packet FIFO, required 0");
      end else void'(pkt_fifo.pop_front());
    end
    if (mp) begin
      checks++;
      if (meta_fifo.size() == 0) begin
        errors++;
        $display("FAIL meta_underflow: o_meta_rden=1 with empty meta FIFO, required 0");
      end else void'(meta_fifo.pop_front());
    end
    refresh();
    checks++;
    if (o_meta_valid && !o_pkt_valid) begin
      errors++;
      $display("FAIL meta_without_pkt: o_meta_valid=1 o_pkt_valid=0, required meta_valid only with a word");
    end
    if (o_pkt_valid) begin
      out_seen++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_word: got %h, required no output", o_pkt);
      end else begin
        e = exp_q.pop_front();
        if (o_pkt !== e.pkt) begin
          errors++;
          $display("FAIL pkt_word: got %h, required %h", o_pkt, e.pkt);
        end
        checks++;
        if (o_meta_valid !== e.mv) begin
          errors++;
          $display("FAIL meta_valid: got %b, required %b (word %h)", o_meta_valid, e.mv, e.pkt);
        end
        if (e.mv) begin
          checks++;
          if (o_meta !== e.meta) begin
            errors++;
            $display("FAIL meta_value: got %h, required %h", o_meta, e.meta);
          end
        end
      end
    end
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      tick();
      n++;
    end
    tick();
    tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d words still pending, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_counts(input string name);
    checks++;
    if (o_pkt_cnt !== CW'(exp_pkt_cnt)) begin
      errors++;
      $display("FAIL %s_pkt_cnt: got %0d, required %0d", name, o_pkt_cnt, exp_pkt_cnt);
    end
    checks++;
    if (o_resync_cnt !== CW'(exp_resync_cnt)) begin
      errors++;
      $display("FAIL %s_resync_cnt: got %0d, required %0d", name, o_resync_cnt, exp_resync_cnt);
    end
    checks++;
    if (o_trunc_cnt !== CW'(exp_trunc_cnt)) begin
      errors++;
      $display("FAIL %s_trunc_cnt: got %0d, required %0d", name, o_trunc_cnt, exp_trunc_cnt);
    end
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if ({o_pkt_valid, o_meta_valid, o_pkt_rden, o_meta_rden} !== 4'b0) begin
      errors++;
      $display("FAIL %s_flags: valid/meta_valid/rden/meta_rden=%b, required 0000", name,
               {o_pkt_valid, o_meta_valid, o_pkt_rden, o_meta_rden});
    end
    checks++;
    if (o_pkt !== '0 || o_meta !== '0) begin
      errors++;
      $display("FAIL %s_data: o_pkt=%h o_meta=%h, required 0", name, o_pkt, o_meta);
    end
    check_counts(name);
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    #1;
    check_all_zero("reset");
    i_rst_n = 1'b1;
    tick();
    check_all_zero("after_reset");
  endtask

  task automatic test_basic_pkt();
    push_meta(32'hA5A5_0001);
    push_pkt(2'b01, 32'h1001);
    push_pkt(2'b00, 32'h1002);
    push_pkt(2'b10, 32'h1003);
    expect_word(2'b01, 32'h1001, 1'b1, 32'hA5A5_0001);
    expect_word(2'b00, 32'h1002, 1'b0, 32'h0);
    expect_word(2'b10, 32'h1003, 1'b0, 32'h0);
    exp_pkt_cnt++;
    drain("basic");
    check_counts("basic");
    checks++;
    if (o_meta !== mkm(32'hA5A5_0001) || o_pkt !== mk(2'b10, 32'h1003)) begin
      errors++;
      $display("FAIL basic_hold: o_meta=%h o_pkt=%h, required last meta and tail word held", o_meta, o_pkt);
    end
  endtask

  task automatic test_meta_wait();
    int seen0;
    push_pkt(2'b01, 32'h2001);
    push_pkt(2'b10, 32'h2002);
    seen0 = out_seen;
    repeat (20) tick();
    checks++;
    if (out_seen != seen0 || pkt_fifo.size() != 2) begin
      errors++;
      $display("FAIL meta_wait_hold: %0d words out, fifo depth %0d, required 0 out, depth 2",
               out_seen - seen0, pkt_fifo.size());
    end
    push_meta(32'hBEEF_0002);
    expect_word(2'b01, 32'h2001, 1'b1, 32'hBEEF_0002);
    expect_word(2'b10, 32'h2002, 1'b0, 32'h0);
    exp_pkt_cnt++;
    tick();
    checks++;
    if (o_pkt_valid !== 1'b1 || o_meta_valid !== 1'b1) begin
      errors++;
      $display("FAIL meta_wait_latency: valid=%b meta_valid=%b one cycle after meta, required 1 1",
               o_pkt_valid, o_meta_valid);
    end
    drain("meta_wait");
    check_counts("meta_wait");
  endtask

  task automatic test_backpressure();
    int seen0;
    push_meta(32'hC0DE_0003);
    push_pkt(2'b01, 32'h3001);
    for (int i = 0; i < 4; i++) push_pkt(2'b00, 32'h3002 + i);
    push_pkt(2'b10, 32'h3006);
    expect_word(2'b01, 32'h3001, 1'b1, 32'hC0DE_0003);
    for (int i = 0; i < 4; i++) expect_word(2'b00, 32'h3002 + i, 1'b0, 32'h0);
    expect_word(2'b10, 32'h3006, 1'b0, 32'h0);
    exp_pkt_cnt++;
    tick();
    tick();
    i_out_ready = 1'b0;
    checks++;
    if (o_pkt_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_inflight: o_pkt_valid=%b as ready drops, required 1", o_pkt_valid);
    end
    seen0 = out_seen;
    repeat (5) tick();
    checks++;
    if (out_seen != seen0 || pkt_fifo.size() != 4) begin
      errors++;
      $display("FAIL bp_stall: %0d words out, fifo depth %0d, required 0 out, depth 4",
               out_seen - seen0, pkt_fifo.size());
    end
    i_out_ready = 1'b1;
    drain("backpressure");
    check_counts("backpressure");
  endtask

  task automatic test_resync();
    push_pkt(2'b00, 32'h4001);
    push_pkt(2'b10, 32'h4002);
    push_meta(32'hD00D_0004);
    push_pkt(2'b01, 32'h4003);
    push_pkt(2'b10, 32'h4004);
    expect_word(2'b01, 32'h4003, 1'b1, 32'hD00D_0004);
    expect_word(2'b10, 32'h4004, 1'b0, 32'h0);
    exp_resync_cnt += 2;
    exp_pkt_cnt++;
    drain("resync");
    check_counts("resync");
  endtask

  task automatic test_trunc_single();
    push_meta(32'hE000_0051);
    push_meta(32'hE000_0052);
    push_meta(32'hE000_0053);
    push_pkt(2'b01, 32'h5001);
    push_pkt(2'b00, 32'h5002);
    push_pkt(2'b01, 32'h5003);
    push_pkt(2'b10, 32'h5004);
    push_pkt(2'b11, 32'h5005);
    expect_word(2'b01, 32'h5001, 1'b1, 32'hE000_0051);
    expect_word(2'b00, 32'h5002, 1'b0, 32'h0);
    expect_word(2'b01, 32'h5003, 1'b1, 32'hE000_0052);
    expect_word(2'b10, 32'h5004, 1'b0, 32'h0);
    expect_word(2'b11, 32'h5005, 1'b1, 32'hE000_0053);
    exp_trunc_cnt++;
    exp_pkt_cnt += 2;
    drain("trunc");
    check_counts("trunc");
    checks++;
    if (pkt_fifo.size() != 0 || meta_fifo.size() != 0) begin
      errors++;
      $display("FAIL trunc_fifos: depths %0d/%0d, required 0/0", pkt_fifo.size(), meta_fifo.size());
    end
  endtask

  task automatic test_reset_mid_send();
    push_meta(32'hF000_0061);
    push_pkt(2'b01, 32'h6001);
    push_pkt(2'b00, 32'h6002);
    push_pkt(2'b00, 32'h6003);
    push_pkt(2'b10, 32'h6004);
    push_meta(32'hF000_0062);
    push_pkt(2'b01, 32'h6005);
    push_pkt(2'b10, 32'h6006);
    expect_word(2'b01, 32'h6001, 1'b1, 32'hF000_0061);
    expect_word(2'b00, 32'h6002, 1'b0, 32'h0);
    tick();
    tick();
    i_rst_n = 1'b0;
    #1;
    exp_pkt_cnt = 0;
    exp_resync_cnt = 0;
    exp_trunc_cnt = 0;
    check_all_zero("mid_reset");
    repeat (2) tick();
    checks++;
    if (pkt_fifo.size() != 4 || meta_fifo.size() != 1) begin
      errors++;
      $display("FAIL mid_reset_fifos: depths %0d/%0d, required 4/1", pkt_fifo.size(), meta_fifo.size());
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL mid_reset_pending: %0d words not seen before reset, required 0", exp_q.size());
      exp_q.delete();
    end
    i_rst_n = 1'b1;
    expect_word(2'b01, 32'h6005, 1'b1, 32'hF000_0062);
    expect_word(2'b10, 32'h6006, 1'b0, 32'h0);
    exp_resync_cnt = 2;
    exp_pkt_cnt = 1;
    drain("after_mid_reset");
    check_counts("after_mid_reset");
  endtask

  initial begin
    refresh();
    repeat (2) @(posedge i_clk);
    #1;
    test_reset();
    test_basic_pkt();
    test_meta_wait();
    test_backpressure();
    test_resync();
    test_trunc_single();
    test_reset_mid_send();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
